// File: rtl/reset_pkg.sv
// Shared definitions for the reset request generator: cause bit positions and FSM encoding.
// Pure declarations, so there is no latency or backpressure.
package reset_pkg;

  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_W   = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_request_gen_if.sv
// Control and status bundle between reset_request_gen and its software/watchdog side.
// Plain strobes and levels, with no handshake and no backpressure.
interface reset_request_gen_if;

  logic       sw_req;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       cause_clr;
  logic       req;
  logic [2:0] cause;

  modport master (
    output sw_req, wdt_enable, wdt_kick, cause_clr,
    input  req, cause
  );

  modport slave (
    input  sw_req, wdt_enable, wdt_kick, cause_clr,
    output req, cause
  );

endinterface

// File: rtl/reset_request_gen_button_debouncer.sv
// Button path: 2-flop synchronizer, debounce, and a registered strobe on the debounced press.
// The strobe follows 2 + DEBOUNCE_CYCLES + 1 cycles after btn_n settles low. No backpressure.
module button_debouncer
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic btn_evt
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      deb     <= 1'b1;
      deb_d   <= 1'b1;
      cnt     <= '0;
      btn_evt <= 1'b0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      deb_d   <= deb;
      // A press is reported only as a debounced 1->0 edge; a release produces nothing.
      btn_evt <= deb_d & ~deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_request_gen.sv
// Merges button, software and (with RESET_REQ_WDT_EN) watchdog events into one req pulse, and records a sticky cause.
// Latency: sw_req to req takes 2 cycles. No backpressure; an event during a pulse restarts the pulse width.
module reset_request_gen
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int WDT_CYCLES       = 16777216,
  parameter int REQ_PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn_n,
  reset_request_gen_if.slave   bus
);

  localparam int            PW         = cnt_width(REQ_PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(REQ_PULSE_CYCLES - 1);

  logic               btn_evt;
  logic               sw_evt;
  logic               wdt_evt;
  logic               clr_q;
  logic               evt_any;
  logic [CAUSE_W-1:0] cause_set;
  logic [CAUSE_W-1:0] cause_q;
  logic [PW-1:0]      pcnt;
  state_t             state;
  state_t             state_nxt;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_n),
    .btn_evt (btn_evt)
  );

  // cause_clr is delayed along with sw_req so that a clear and a set on the same input cycle meet in the cause flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_evt <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      sw_evt <= bus.sw_req;
      clr_q  <= bus.cause_clr;
    end
  end

`ifdef RESET_REQ_WDT_EN
  localparam int            WW       = cnt_width(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt    <= '0;
      wdt_evt <= 1'b0;
    end else begin
      wdt_evt <= 1'b0;
      if (!bus.wdt_enable || bus.wdt_kick || state == ACTIVE) begin
        wcnt <= '0;
      end else if (wcnt == WDT_LAST) begin
        wcnt    <= '0;
        wdt_evt <= 1'b1;
      end else begin
        wcnt <= wcnt + WW'(1);
      end
    end
  end
`else
  localparam int UNUSED_WDT_CYCLES = WDT_CYCLES;
  logic unused_wdt;
  assign unused_wdt = ^{bus.wdt_enable, bus.wdt_kick};
  assign wdt_evt    = 1'b0;
`endif

  assign evt_any = btn_evt | sw_evt | wdt_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (evt_any) state_nxt = ACTIVE;
      ACTIVE:  if (!evt_any && pcnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req comes straight off the state flop, so it is registered and glitch-free.
  always_comb begin
    bus.req = (state == ACTIVE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (evt_any) begin
      pcnt <= PULSE_LAST;
    end else if (state == ACTIVE && pcnt != '0) begin
      pcnt <= pcnt - PW'(1);
    end
  end

  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_BTN] = btn_evt;
    cause_set[CAUSE_SW]  = sw_evt;
    cause_set[CAUSE_WDT] = wdt_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cause_q <= '0;
    else          cause_q <= (clr_q ? '0 : cause_q) | cause_set;
  end

  assign bus.cause = cause_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Scoreboard bench for reset_request_gen: stimulus queues expected pulses and probes, a monitor compares them.
module tb_reset_request_gen;

  localparam int DEB = 8;
  localparam int WDT = 32;
  localparam int PUL = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic btn_n   = 1'b1;

  reset_request_gen_if bus();

  reset_request_gen #(
    .DEBOUNCE_CYCLES  (DEB),
    .WDT_CYCLES       (WDT),
    .REQ_PULSE_CYCLES (PUL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         start;
    int         width;
    logic [2:0] cause;
  } pulse_t;

  typedef struct {
    int         due;
    logic       req;
    logic [2:0] cause;
    string      name;
  } probe_t;

  pulse_t pq[$];
  probe_t prq[$];
  int     checks = 0;
  int     errors = 0;
  bit     done   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares.
  logic   req_prev = 1'b0;
  bit     tracking = 1'b0;
  int     rise_cyc = 0;
  pulse_t cur;
  probe_t p;

  always @(negedge clk) begin
    if (bus.req && !req_prev) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: req rose at cycle %0d, expected no pulse", cyc);
      end else begin
        cur      = pq.pop_front();
        tracking = 1'b1;
        rise_cyc = cyc;
        chk("pulse_start", cyc, cur.start);
        chk("pulse_cause", int'(bus.cause), int'(cur.cause));
      end
    end else if (!bus.req && req_prev && tracking) begin
      chk("pulse_width", cyc - rise_cyc, cur.width);
      tracking = 1'b0;
    end
    if (!bus.req && pq.size() > 0 && cyc > pq[0].start + 2) begin
      chk("missing_pulse_start", -1, pq[0].start);
      void'(pq.pop_front());
    end
    while (prq.size() > 0 && prq[0].due <= cyc) begin
      p = prq.pop_front();
      chk({p.name, "_req"},   int'(bus.req),   int'(p.req));
      chk({p.name, "_cause"}, int'(bus.cause), int'(p.cause));
    end
    req_prev = bus.req;
    if (done || cyc > 20000) begin
      if (!done) chk("timeout_cycle", cyc, 0);
      foreach (pq[i]) chk("missing_pulse_start", -1, pq[i].start);
      foreach (prq[i]) chk({prq[i].name, "_not_reached"}, cyc, prq[i].due);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int start, input int width, input logic [2:0] c);
    pulse_t e;
    e.start = start;
    e.width = width;
    e.cause = c;
    pq.push_back(e);
  endtask

  task automatic probe(input int dly, input logic r, input logic [2:0] c, input string nm);
    probe_t e;
    e.due   = cyc + dly;
    e.req   = r;
    e.cause = c;
    e.name  = nm;
    prq.push_back(e);
  endtask

  task automatic sw_pulse();
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
  endtask

  initial begin
    bus.sw_req     = 1'b0;
    bus.wdt_enable = 1'b0;
    bus.wdt_kick   = 1'b0;
    bus.cause_clr  = 1'b0;
    #2 reset_n = 1'b0;
    tick(3);
    probe(1, 1'b0, 3'b000, "reset");
    tick(2);
    reset_n = 1'b1;
    tick(5);
    probe(1, 1'b0, 3'b000, "post_release");
    tick(5);

    // Software request: rise 2 cycles later, 4 cycles wide.
    push_pulse(cyc + 2, PUL, 3'b010);
    sw_pulse();
    tick(10);
    probe(1, 1'b0, 3'b010, "sw_cause");
    tick(2);

    // Bouncy press: only the final low level counts; req 12 cycles after it settles.
    btn_n = 1'b0;
    tick(5);
    btn_n = 1'b1;
    tick(1);
    btn_n = 1'b0;
    push_pulse(cyc + 2 + DEB + 2, PUL, 3'b011);
    tick(220);
    probe(1, 1'b0, 3'b011, "btn_hold");
    btn_n = 1'b1;
    tick(30);
    probe(1, 1'b0, 3'b011, "btn_release");
    tick(2);

    // Clear with no event.
    bus.cause_clr = 1'b1;
    probe(1, 1'b0, 3'b011, "clr_pending");
    tick(1);
    bus.cause_clr = 1'b0;
    probe(2, 1'b0, 3'b000, "clr_alone");
    tick(5);

`ifdef RESET_REQ_WDT_EN
    // Expiry after 32 enabled cycles, then req one cycle later.
    bus.wdt_enable = 1'b1;
    push_pulse(cyc + WDT + 1, PUL, 3'b100);
    tick(40);
    bus.wdt_enable = 1'b0;
    tick(5);
    probe(1, 1'b0, 3'b100, "wdt_cause");
    tick(1);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;
    probe(2, 1'b0, 3'b000, "wdt_clr");
    tick(5);

    bus.wdt_enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick(19);
      bus.wdt_kick = 1'b1;
      tick(1);
      bus.wdt_kick = 1'b0;
    end
    bus.wdt_enable = 1'b0;
    probe(1, 1'b0, 3'b000, "wdt_kicked");
    tick(3);

    // Kick lands exactly on the terminal count.
    bus.wdt_enable = 1'b1;
    tick(WDT - 1);
    bus.wdt_kick = 1'b1;
    tick(1);
    bus.wdt_kick = 1'b0;
    tick(18);
    bus.wdt_enable = 1'b0;
    probe(1, 1'b0, 3'b000, "wdt_term_kick");
    tick(10);
`else
    bus.wdt_enable = 1'b1;
    bus.wdt_kick   = 1'b0;
    tick(100);
    bus.wdt_enable = 1'b0;
    probe(1, 1'b0, 3'b000, "wdt_off");
    tick(5);
`endif

    // Second request 3 cycles after the first stretches req to 7 cycles.
    push_pulse(cyc + 2, 7, 3'b010);
    sw_pulse();
    tick(2);
    sw_pulse();
    tick(15);

    // Set and clear on the same cycle: the set wins.
    push_pulse(cyc + 2, PUL, 3'b010);
    bus.sw_req    = 1'b1;
    bus.cause_clr = 1'b1;
    probe(1, 1'b0, 3'b010, "setclr_c1");
    probe(2, 1'b1, 3'b010, "setclr_c2");
    probe(3, 1'b1, 3'b010, "setclr_c3");
    tick(1);
    bus.sw_req    = 1'b0;
    bus.cause_clr = 1'b0;
    tick(10);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;
    probe(2, 1'b0, 3'b000, "clr_final");
    tick(5);

    // Reset mid-pulse truncates req to the 2 cycles already seen.
    push_pulse(cyc + 2, 2, 3'b010);
    sw_pulse();
    tick(2);
    @(posedge clk);
    #1 reset_n = 1'b0;
    probe(0, 1'b0, 3'b000, "async_reset");
    tick(3);
    reset_n = 1'b1;
    tick(40);
    probe(1, 1'b0, 3'b000, "post_reset_idle");
    tick(3);
    done = 1'b1;
  end

endmodule

// File: doc/reset_request_gen.md
Name: reset_request_gen

Overview:
- Collects reset sources and produces the single `req` pulse consumed by the logic reset controller's `req` input.
- Sources:
  - external push button: asynchronous, active-low, bouncy
  - software reset strobe
  - watchdog timer
- Records which source fired in a sticky cause register that software can read after reset.
- Runs on the PLL output clock. It is reset only by the board power-on reset, never by `reset_logic`, so the cause register survives a logic reset.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a button level change is accepted (min 2).
- WDT_CYCLES, 16777216: enabled cycles without a kick before the watchdog expires (min 2).
- REQ_PULSE_CYCLES, 16: width of the `req` pulse in clk cycles (min 1).

Ports:
- clk  in  1  PLL-domain clock
- reset_n  in  1  asynchronous active-low reset
- btn_n  in  1  raw button, active-low, asynchronous to clk
- sw_req  in  1  single-cycle software reset request
- wdt_enable  in  1  watchdog run enable
- wdt_kick  in  1  single-cycle watchdog service strobe
- cause_clr  in  1  single-cycle clear of cause register
- req  out  1  reset request pulse to the reset controller
- cause  out  3  sticky cause: [0] button, [1] software, [2] watchdog

Behaviour:
- Reset (reset_n low, asynchronous): `req`=0, `cause`=3'b000, state=IDLE, all counters 0.
  - Synchronizer flops and debounced level reset to 1 (released).
  - Deassertion is synchronous to clk; no events are generated in the first cycle after deassertion.
- Button path:
  - 2-flop synchronizer, then debounce.
  - Debounce counter increments while the synced level differs from the debounced level; it clears whenever the two match.
  - On reaching DEBOUNCE_CYCLES-1 the debounced level takes the synced value and the counter clears.
  - `btn_evt` is a 1-cycle strobe on the debounced 1->0 transition only.
  - Release and a held button generate nothing further.
- Watchdog:
  - Counter is cleared while wdt_enable=0, wdt_kick=1, or state=ACTIVE; otherwise it increments.
  - At count WDT_CYCLES-1 with no kick in the same cycle: `wdt_evt` strobe for 1 cycle, counter clears.
  - Kick in the same cycle as terminal count wins (no expiry).
- sw_req: `sw_evt` = sw_req, registered once. Multi-cycle assertion is legal; each high cycle is an event.
- State machine (IDLE, ACTIVE):
  - IDLE -> ACTIVE on any event. `req` goes high the next clk edge; pulse counter loads REQ_PULSE_CYCLES-1.
  - ACTIVE: `req`=1; counter decrements each cycle. At 0 -> IDLE, `req`=0.
  - An event during ACTIVE reloads the counter (pulse extends). `req` never drops between back-to-back events.
  - `req` is registered, glitch-free, and high for exactly REQ_PULSE_CYCLES cycles for an isolated event.
- Cause register:
  - Each event sets its bit in the cycle after the event; bits are sticky across pulses.
  - Simultaneous events set multiple bits.
  - cause_clr clears all bits; a set in the same cycle as cause_clr wins for that bit.
- Latency:
  - sw_req high at edge N -> `req` high after edge N+2.
  - Button: 2 sync + DEBOUNCE_CYCLES + 2 cycles from btn_n settling low to `req` high.
- Widths:
  - Counters are $clog2(param) bits, or $clog2(param+1) where the terminal value must be representable.
  - No counter wraps; each clears explicitly.

Optional Feature:
- Macro RESET_REQ_WDT_EN.
- Defined: watchdog as above.
- Undefined: no watchdog counter is synthesized; wdt_enable and wdt_kick are ignored; cause[2] is tied to 0.

Decomposition:
- Shared package reset_pkg:
  - cause bit index constants CAUSE_BTN=0, CAUSE_SW=1, CAUSE_WDT=2
  - state encoding typedef (IDLE=0, ACTIVE=1)
- One sub-module: button_debouncer (synchronizer + debounce counter + falling-edge strobe, parameter DEBOUNCE_CYCLES).

Test Plan (DEBOUNCE_CYCLES=8, WDT_CYCLES=32, REQ_PULSE_CYCLES=4):
- Software event: sw_req 1 cycle at cycle 10 -> req high cycles 12-15, low at 16; cause=3'b010.
- Bounce rejection: btn_n low 5 cycles, high 1, low 20 -> exactly one 4-cycle req pulse; no req during bounce; cause[0]=1; hold btn_n low 200 more cycles -> no further pulse.
- Watchdog expiry and kick: wdt_enable=1, no kicks -> req pulse, cause[2]=1 after 32 enabled cycles. Repeat with kick every 20 cycles -> no pulse over 500 cycles. Kick at terminal count -> no expiry.
- Pulse extension and cause clear: sw_req at cycle 10 and again at 13 -> req continuous high 12-18. cause_clr with simultaneous sw_req -> cause[1] stays 1; cause_clr alone -> 0.
- Mid-pulse reset: reset_n low during ACTIVE -> req and cause 0 immediately, asynchronously; after release no spurious pulse with btn_n=1.
- Macro off: build without RESET_REQ_WDT_EN, wdt_enable=1 for 100 cycles -> req stays 0, cause[2]=0.
